lfsr_crypt_engine: RTL and testbench
====================================

# lfsr_crypt_engine

Hardware LFSR stream-cipher engine, the fixed-function successor to the programmable message-encryption run (Program #1). On a start request it reads configuration and a raw message from the shared single-port data memory. It then pads the message with ASCII spaces, XORs each byte with a maximal-length LFSR sequence and writes the result back, with a parity bit inserted in each byte's MSB. A decrypt mode runs the same sequence in reverse: it regenerates the keystream, strips parity, counts parity errors and writes the plaintext.

## Interface
- LFSR_W, 7: LFSR state width.
- DATA_W, 8: memory byte width. Requires LFSR_W <= DATA_W-1.
- MSG_LEN, 64: padded output length in bytes.
- RAW_LEN, 49: maximum raw message bytes.
- PRE_MIN, 10 / PRE_MAX, 15: preamble clamp bounds.
- MEM_AW, 8: memory address width.
- CFG_ADDR, 61: pre_length at CFG_ADDR, pt_no at +1, lfsr_init at +2.
- SRC_BASE, 0 / DST_BASE, 64 / PLAIN_BASE, 128: raw-in, cipher, and decrypt-out bases.
- clk  in  1  single clock, rising edge.
- init  in  1  asynchronous, active-high reset.
- req  in  1  start request; a run is launched by the falling edge of req.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on the launch cycle.
- mem_addr  out  MEM_AW  memory address.
- mem_we  out  1  write strobe.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid one cycle after mem_addr.
- ack  out  1  run complete.
- cfg_err  out  1  pt_no was out of range during the last run.
- par_err_cnt  out  $clog2(MSG_LEN+1)  parity failures in the last decrypt.

## Operation
- **IDLE.** Wait for req sampled 1 then 0; this falling edge launches a run. Latch mode, then go to CFG.
- **CFG** (4 cycles):
  - Issue reads at CFG_ADDR, +1 and +2 on consecutive cycles; capture each value one cycle later.
  - pre_length is clamped to [PRE_MIN, PRE_MAX].
  - pt_no >= 9 selects pattern 0 and sets cfg_err.
  - lfsr_init == 0 is replaced by 1.
- **RUN.** Byte index i runs 0..MSG_LEN-1, with two cycles per byte (RD, then WR).
  - Encrypt, input byte p:
    - Inside the message window, pre_length <= i < pre_length+RAW_LEN: read SRC_BASE+(i-pre_length) and use it as p.
    - Outside the window: p = 0x20, RD is a dummy read at the same address, and the fixed cycle count is kept.
  - Encrypt, output byte c:
    - c = p ^ zero-extended lfsr.
    - c[DATA_W-1] = XOR reduction of c[DATA_W-2:0].
    - Write c to DST_BASE+i.
  - Decrypt:
    - Read c from DST_BASE+i.
    - If the XOR reduction of all c bits is 1, increment par_err_cnt.
    - Compute q = (c ^ lfsr) with MSB forced to 0, and write q to PLAIN_BASE+i.
  - LFSR:
    - Byte 0 uses lfsr_init.
    - After each WR, lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & taps[pt_no])}.
- **DONE.** ack = 1 and is held until req returns to 1, then go to IDLE.
  - A req falling edge seen during CFG or RUN is ignored.
  - cfg_err and par_err_cnt hold until the next launch, which clears them.
- **Reset.** init asserted at any time gives:
  - state IDLE, ack = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0;
  - cfg_err = 0, par_err_cnt = 0, lfsr = 1.
  - A run interrupted by reset is abandoned; the bytes already written remain in memory.

## Timing
- mem_we is asserted only in WR cycles: exactly MSG_LEN write pulses per run.
- Encrypt and decrypt have the same latency.
  - Launch cycle L is the first cycle with req = 0 after req = 1.
  - CFG occupies L+1..L+4.
  - RUN occupies L+5..L+4+2*MSG_LEN.
  - ack rises at L+5+2*MSG_LEN.
- Address arithmetic is modulo 2^MEM_AW.
- The index counter saturates at MSG_LEN-1; there is no wrap-around within a run.
- If req stays 0 after ack, ack stays 1 and no relaunch occurs.

## Structure
- **Package lfsr_crypt_pkg** holds:
  - the 9-entry tap table for LFSR_W = 7: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B;
  - the state enum {IDLE, CFG, RUN, DONE};
  - the PAD_CHAR constant 0x20;
  - a parity function.
- Any other LFSR_W requires its own package tap table; a missing table is an elaboration error.
- **Sub-module lfsr_step:** a combinational next-state function with inputs state and taps.

## Test plan
- Encrypt with pt_no = 0, init = 0x01, pre_length = 10, message "Mr. Watson, come here. I want to see you.":
  - bytes 64..66 = 0x21, 0x22, 0x24;
  - all 64 bytes match the bench model;
  - ack at L+133.
- Clamping, with pre_length = 3 and then 40:
  - the message window starts at 10 and 15 respectively;
  - lfsr_init = 0 behaves as init = 1.
- pt_no = 12:
  - cfg_err = 1 and pattern 0 is used;
  - the next valid run clears cfg_err.
- Decrypt of the encrypt output:
  - PLAIN_BASE region = the padded message with MSB 0;
  - par_err_cnt = 0.
  - After flipping bit 3 of two cipher bytes: par_err_cnt = 2.
- Assert init at RUN byte 20:
  - ack = 0, no further mem_we, state IDLE;
  - the next launch produces a complete correct run.
- Extra req falling edge at mid-RUN:
  - it is ignored;
  - ack holds while req = 0 and drops the cycle after req rises.

Source files
------------

// File: rtl/lfsr_crypt_pkg.sv
// Shared constants, state encoding, tap table and parity helper for the
// LFSR stream-cipher engine.
package lfsr_crypt_pkg;

    localparam int LFSR_W      = 7;
    localparam int DATA_W      = 8;
    localparam int MSG_LEN     = 64;
    localparam int RAW_LEN     = 49;
    localparam int PRE_MIN     = 10;
    localparam int PRE_MAX     = 15;
    localparam int MEM_AW      = 8;
    localparam int CFG_ADDR    = 61;
    localparam int SRC_BASE    = 0;
    localparam int DST_BASE    = 64;
    localparam int PLAIN_BASE  = 128;
    localparam int N_PATTERNS  = 9;
    localparam int TAP_TABLE_W = 7;

    localparam int IDX_W = $clog2(MSG_LEN);
    localparam int CNT_W = $clog2(MSG_LEN + 1);
    localparam int PRE_W = 4;
    localparam int PT_W  = 4;

    localparam logic [DATA_W-1:0] PAD_CHAR  = 8'h20;
    localparam logic [LFSR_W-1:0] LFSR_ONE  = {{(LFSR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Feedback taps for the 7-bit LFSR; out-of-range selectors fall back to pattern 0.
    function automatic logic [LFSR_W-1:0] taps_for(input logic [PT_W-1:0] pt);
        logic [LFSR_W-1:0] t;
        case (pt)
            4'd0:    t = 7'h60;
            4'd1:    t = 7'h48;
            4'd2:    t = 7'h78;
            4'd3:    t = 7'h72;
            4'd4:    t = 7'h6A;
            4'd5:    t = 7'h69;
            4'd6:    t = 7'h5C;
            4'd7:    t = 7'h7E;
            4'd8:    t = 7'h7B;
            default: t = 7'h60;
        endcase
        return t;
    endfunction

    function automatic logic parity(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One step of a Fibonacci-style LFSR: shift left, feed the tapped XOR into bit 0.
module lfsr_step
    import lfsr_crypt_pkg::*;
#(
    parameter int W = LFSR_W
) (
    input  logic [W-1:0] state_i,
    input  logic [W-1:0] taps_i,
    output logic [W-1:0] next_o
);

    assign next_o = {state_i[W-2:0], ^(state_i & taps_i)};

endmodule

// File: rtl/lfsr_crypt_engine.sv
// LFSR stream-cipher engine: reads config and message from the shared memory,
// then encrypts (with per-byte parity) or decrypts (counting parity errors).
module lfsr_crypt_engine
    import lfsr_crypt_pkg::*;
(
    input  logic              clk_i,
    input  logic              init_i,
    input  logic              req_i,
    input  logic              mode_i,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              ack_o,
    output logic              cfg_err_o,
    output logic [CNT_W-1:0]  par_err_cnt_o
);

    if (LFSR_W != TAP_TABLE_W || LFSR_W > DATA_W - 1) begin : g_bad_lfsr_w
        $error("lfsr_crypt_engine: no tap table for this LFSR_W/DATA_W combination");
    end

    state_e             state_q, state_d;
    logic               req_q;
    logic               mode_q, mode_d;
    logic [1:0]         cfg_cnt_q, cfg_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [PRE_W-1:0]   pre_len_q, pre_len_d;
    logic [PT_W-1:0]    pt_q, pt_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [MEM_AW-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic               ack_q, ack_d;
    logic               cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]   par_cnt_q, par_cnt_d;

    logic [LFSR_W-1:0]  taps_s;
    logic [LFSR_W-1:0]  lfsr_next_s;
    logic               in_win_s;
    logic [DATA_W-1:0]  ks_s;
    logic [DATA_W-1:0]  plain_s;
    logic [DATA_W-1:0]  enc_s;
    logic [DATA_W-1:0]  dec_s;
    logic [DATA_W-1:0]  wdata_s;

    function automatic logic [PRE_W-1:0] clamp_pre(input logic [DATA_W-1:0] v);
        logic [PRE_W-1:0] r;
        if (v < DATA_W'(PRE_MIN)) begin
            r = PRE_W'(PRE_MIN);
        end else if (v > DATA_W'(PRE_MAX)) begin
            r = PRE_W'(PRE_MAX);
        end else begin
            r = v[PRE_W-1:0];
        end
        return r;
    endfunction

    // Encrypt reads SRC_BASE+(i-pre) even outside the window so every byte costs the same.
    function automatic logic [MEM_AW-1:0] rd_addr(input logic dec, input logic [PRE_W-1:0] pre,
                                                  input logic [IDX_W-1:0] idx);
        logic [MEM_AW-1:0] a;
        if (dec) begin
            a = MEM_AW'(DST_BASE) + MEM_AW'(idx);
        end else begin
            a = MEM_AW'(SRC_BASE) + MEM_AW'(idx) - MEM_AW'(pre);
        end
        return a;
    endfunction

    function automatic logic [MEM_AW-1:0] wr_addr(input logic dec, input logic [IDX_W-1:0] idx);
        logic [MEM_AW-1:0] a;
        if (dec) begin
            a = MEM_AW'(PLAIN_BASE) + MEM_AW'(idx);
        end else begin
            a = MEM_AW'(DST_BASE) + MEM_AW'(idx);
        end
        return a;
    endfunction

    assign taps_s = taps_for(pt_q);

    lfsr_step #(.W(LFSR_W)) u_step (
        .state_i (lfsr_q),
        .taps_i  (taps_s),
        .next_o  (lfsr_next_s)
    );

    // Byte datapath; read data only arrives in the WR cycle, so write data is formed there.
    always_comb begin
        in_win_s = (MEM_AW'(idx_q) >= MEM_AW'(pre_len_q)) &&
                   (MEM_AW'(idx_q) <  MEM_AW'(pre_len_q) + MEM_AW'(RAW_LEN));
        ks_s     = {{(DATA_W-LFSR_W){1'b0}}, lfsr_q};
        if (in_win_s) begin
            plain_s = mem_rdata_i;
        end else begin
            plain_s = PAD_CHAR;
        end
        enc_s            = plain_s ^ ks_s;
        enc_s[DATA_W-1]  = parity({1'b0, enc_s[DATA_W-2:0]});
        dec_s            = mem_rdata_i ^ ks_s;
        dec_s[DATA_W-1]  = 1'b0;
        if (mode_q) begin
            wdata_s = dec_s;
        end else begin
            wdata_s = enc_s;
        end
        if (we_q) begin
            mem_wdata_o = wdata_s;
        end else begin
            mem_wdata_o = {DATA_W{1'b0}};
        end
    end

    // Next-state logic for the controller and all run registers.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cfg_cnt_d = cfg_cnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        pre_len_d = pre_len_q;
        pt_d      = pt_q;
        lfsr_d    = lfsr_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        ack_d     = ack_q;
        cfg_err_d = cfg_err_q;
        par_cnt_d = par_cnt_q;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_q && !req_i) begin
                    state_d   = CFG;
                    mode_d    = mode_i;
                    cfg_cnt_d = 2'd0;
                    addr_d    = MEM_AW'(CFG_ADDR);
                    cfg_err_d = 1'b0;
                    par_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            CFG: begin
                cfg_cnt_d = cfg_cnt_q + 2'd1;
                case (cfg_cnt_q)
                    2'd0: addr_d = MEM_AW'(CFG_ADDR + 1);
                    2'd1: begin
                        addr_d    = MEM_AW'(CFG_ADDR + 2);
                        pre_len_d = clamp_pre(mem_rdata_i);
                    end
                    2'd2: begin
                        if (mem_rdata_i >= DATA_W'(N_PATTERNS)) begin
                            pt_d      = {PT_W{1'b0}};
                            cfg_err_d = 1'b1;
                        end else begin
                            pt_d      = mem_rdata_i[PT_W-1:0];
                            cfg_err_d = 1'b0;
                        end
                    end
                    2'd3: begin
                        if (mem_rdata_i[LFSR_W-1:0] == {LFSR_W{1'b0}}) begin
                            lfsr_d = LFSR_ONE;
                        end else begin
                            lfsr_d = mem_rdata_i[LFSR_W-1:0];
                        end
                        state_d = RUN;
                        idx_d   = {IDX_W{1'b0}};
                        wr_d    = 1'b0;
                        addr_d  = rd_addr(mode_q, pre_len_q, {IDX_W{1'b0}});
                    end
                    default: state_d = IDLE;
                endcase
            end
            RUN: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    we_d   = 1'b1;
                    addr_d = wr_addr(mode_q, idx_q);
                end else begin
                    wr_d   = 1'b0;
                    lfsr_d = lfsr_next_s;
                    if (mode_q && parity(mem_rdata_i)) begin
                        par_cnt_d = par_cnt_q + CNT_W'(1);
                    end else begin
                        par_cnt_d = par_cnt_q;
                    end
                    if (idx_q == IDX_W'(MSG_LEN - 1)) begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        addr_d = rd_addr(mode_q, pre_len_q, idx_q + IDX_W'(1));
                    end
                end
            end
            DONE: begin
                if (req_i) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge init_i) begin
        if (init_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            mode_q    <= 1'b0;
            cfg_cnt_q <= 2'd0;
            idx_q     <= {IDX_W{1'b0}};
            wr_q      <= 1'b0;
            pre_len_q <= PRE_W'(PRE_MIN);
            pt_q      <= {PT_W{1'b0}};
            lfsr_q    <= LFSR_ONE;
            addr_q    <= {MEM_AW{1'b0}};
            we_q      <= 1'b0;
            ack_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            par_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            req_q     <= req_i;
            mode_q    <= mode_d;
            cfg_cnt_q <= cfg_cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            pre_len_q <= pre_len_d;
            pt_q      <= pt_d;
            lfsr_q    <= lfsr_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            ack_q     <= ack_d;
            cfg_err_q <= cfg_err_d;
            par_cnt_q <= par_cnt_d;
        end
    end

    assign mem_addr_o    = addr_q;
    assign mem_we_o      = we_q;
    assign ack_o         = ack_q;
    assign cfg_err_o     = cfg_err_q;
    assign par_err_cnt_o = par_cnt_q;

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Randomised self-checking bench for lfsr_crypt_engine against a byte-level
// reference model of the cipher, with a behavioural memory.
module tb_lfsr_crypt_engine;
    import lfsr_crypt_pkg::*;

    logic              clk = 1'b0;
    logic              init;
    logic              req;
    logic              mode;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              ack;
    logic              cfg_err;
    logic [CNT_W-1:0]  par_err_cnt;

    logic [7:0] mem [256];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_wdata;

    int n_checks = 0;
    int n_errors = 0;

    int         taps_tab [9] = '{32'h60, 32'h48, 32'h78, 32'h72, 32'h6A, 32'h69, 32'h5C, 32'h7E, 32'h7B};
    logic [7:0] src_m    [RAW_LEN];
    logic [7:0] ks_m     [MSG_LEN];
    logic [7:0] pad_m    [MSG_LEN];
    logic [7:0] cipher_m [MSG_LEN];
    logic       exp_cfg_err;

    lfsr_crypt_engine dut (
        .clk_i         (clk),
        .init_i        (init),
        .req_i         (req),
        .mode_i        (mode),
        .mem_addr_o    (mem_addr),
        .mem_we_o      (mem_we),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .ack_o         (ack),
        .cfg_err_o     (cfg_err),
        .par_err_cnt_o (par_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_addr] <= tb_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = 8'(a); tb_wdata = 8'(d);
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic setup(input int pre, input int pt, input int ini);
        wr(CFG_ADDR, pre); wr(CFG_ADDR + 1, pt); wr(CFG_ADDR + 2, ini);
        for (int j = 0; j < RAW_LEN; j++) wr(SRC_BASE + j, int'(src_m[j]));
    endtask

    // Reference: clamp config, generate keystream, pad, XOR, add parity bit.
    task automatic model_encrypt(input int pre, input int pt, input int ini);
        int p_eff, t_eff, s, c;
        p_eff = (pre < PRE_MIN) ? PRE_MIN : ((pre > PRE_MAX) ? PRE_MAX : pre);
        exp_cfg_err = (pt >= 9);
        t_eff = (pt >= 9) ? 0 : pt;
        s = ini & 127;
        if (s == 0) s = 1;
        for (int i = 0; i < MSG_LEN; i++) begin
            ks_m[i]  = 8'(s);
            s        = ((s << 1) & 127) | ($countones(s & taps_tab[t_eff]) & 1);
            pad_m[i] = (i >= p_eff && i < p_eff + RAW_LEN) ? src_m[i - p_eff] : 8'h20;
            c        = (int'(pad_m[i]) ^ int'(ks_m[i])) & 127;
            c        = c | (($countones(c) & 1) << 7);
            cipher_m[i] = 8'(c);
        end
    endtask

    task automatic check_cipher(input string tag, input int upto);
        for (int i = 0; i < upto; i++)
            check_val($sformatf("%s_c%0d", tag, i), 32'(mem[DST_BASE + i]), 32'(cipher_m[i]));
    endtask

    task automatic check_plain(input string tag);
        for (int i = 0; i < MSG_LEN; i++)
            check_val($sformatf("%s_p%0d", tag, i), 32'(mem[PLAIN_BASE + i]),
                      32'((cipher_m[i] ^ ks_m[i]) & 8'h7F));
    endtask

    // Launch a run and count cycles from the launch cycle until ack is seen.
    task automatic do_run(input logic m, input int rst_at, input int glitch_at,
                          output int ack_n, output int we_n);
        ack_n = -1; we_n = 0;
        @(negedge clk); mode = m; req = 1'b1;
        @(negedge clk); req = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (mem_we) we_n++;
            if (n == glitch_at) req = 1'b1;
            if (n == glitch_at + 1) req = 1'b0;
            if (n == rst_at) begin
                init = 1'b1;
                break;
            end
            if (ack) begin
                ack_n = n;
                break;
            end
        end
    endtask

    initial begin
        string msg;
        int ack_n, we_n, pre, pt, ini;
        init = 1'b1; req = 1'b0; mode = 1'b0; tb_we = 1'b0; tb_addr = 8'h00; tb_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_we", 32'(mem_we), 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);
        check_val("rst_wdata", 32'(mem_wdata), 32'd0);
        check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
        check_val("rst_par", 32'(par_err_cnt), 32'd0);
        check_val("rst_lfsr", 32'(dut.lfsr_q), 32'd1);
        check_val("rst_state", 32'(dut.state_q), 32'(IDLE));
        init = 1'b0;

        // Reference message encrypt
        msg = "Mr. Watson, come here. I want to see you.";
        for (int j = 0; j < RAW_LEN; j++) src_m[j] = (j < msg.len()) ? 8'(msg[j]) : 8'h20;
        setup(10, 0, 1); model_encrypt(10, 0, 1);
        do_run(1'b0, -1, -1, ack_n, we_n);
        check_val("enc_lat", 32'(ack_n), 32'd133);
        check_val("enc_we", 32'(we_n), 32'd64);
        check_val("enc_b64", 32'(mem[64]), 32'h21);
        check_val("enc_b65", 32'(mem[65]), 32'h22);
        check_val("enc_b66", 32'(mem[66]), 32'h24);
        check_val("enc_cfg_err", 32'(cfg_err), 32'd0);
        check_cipher("msg", MSG_LEN);

        // Decrypt of that ciphertext
        do_run(1'b1, -1, -1, ack_n, we_n);
        check_val("dec_lat", 32'(ack_n), 32'd133);
        check_val("dec_we", 32'(we_n), 32'd64);
        check_val("dec_par", 32'(par_err_cnt), 32'd0);
        for (int i = 0; i < MSG_LEN; i++)
            check_val($sformatf("dec_p%0d", i), 32'(mem[PLAIN_BASE + i]), 32'(pad_m[i] & 8'h7F));

        // Two corrupted cipher bytes
        cipher_m[5]  = cipher_m[5] ^ 8'h08;  wr(DST_BASE + 5, int'(cipher_m[5]));
        cipher_m[30] = cipher_m[30] ^ 8'h08; wr(DST_BASE + 30, int'(cipher_m[30]));
        do_run(1'b1, -1, -1, ack_n, we_n);
        check_val("flip_par", 32'(par_err_cnt), 32'd2);
        check_plain("flip");

        // Preamble clamping and zero seed
        setup(3, 2, 0); model_encrypt(3, 2, 0);
        do_run(1'b0, -1, -1, ack_n, we_n);
        check_val("clamp3_lat", 32'(ack_n), 32'd133);
        check_cipher("clamp3", MSG_LEN);
        setup(40, 4, 0); model_encrypt(40, 4, 0);
        do_run(1'b0, -1, -1, ack_n, we_n);
        check_cipher("clamp40", MSG_LEN);

        // Out-of-range pattern, then a valid one clears the flag
        setup(10, 12, 8'h33); model_encrypt(10, 12, 8'h33);
        do_run(1'b0, -1, -1, ack_n, we_n);
        check_val("pt12_cfg_err", 32'(cfg_err), 32'd1);
        check_cipher("pt12", MSG_LEN);
        setup(10, 1, 8'h33); model_encrypt(10, 1, 8'h33);
        do_run(1'b0, -1, -1, ack_n, we_n);
        check_val("pt1_cfg_err", 32'(cfg_err), 32'd0);
        check_cipher("pt1", MSG_LEN);

        // Reset while byte 20 is being read
        for (int j = 0; j < RAW_LEN; j++) src_m[j] = 8'($urandom_range(0, 255));
        setup(12, 3, 8'h11); model_encrypt(12, 3, 8'h11);
        wr(DST_BASE + 20, 0);
        do_run(1'b0, 45, -1, ack_n, we_n);
        #1;
        check_val("mrst_ack", 32'(ack), 32'd0);
        check_val("mrst_we", 32'(mem_we), 32'd0);
        check_val("mrst_addr", 32'(mem_addr), 32'd0);
        check_val("mrst_state", 32'(dut.state_q), 32'(IDLE));
        repeat (2) @(negedge clk);
        init = 1'b0;
        we_n = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_we) we_n++;
        end
        check_val("mrst_no_we", 32'(we_n), 32'd0);
        check_cipher("mrst_kept", 20);
        check_val("mrst_b20", 32'(mem[DST_BASE + 20]), 32'd0);
        do_run(1'b0, -1, -1, ack_n, we_n);
        check_val("mrst_rerun_lat", 32'(ack_n), 32'd133);
        check_cipher("mrst_rerun", MSG_LEN);

        // Extra req falling edge mid-run, then ack handshake
        do_run(1'b0, -1, 60, ack_n, we_n);
        check_val("glitch_lat", 32'(ack_n), 32'd133);
        check_val("glitch_we", 32'(we_n), 32'd64);
        check_cipher("glitch", MSG_LEN);
        ack_n = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (ack) ack_n++;
        end
        check_val("ack_hold", 32'(ack_n), 32'd5);
        req = 1'b1;
        @(negedge clk);
        check_val("ack_drop", 32'(ack), 32'd0);

        // Random configurations: encrypt then decrypt
        for (int r = 0; r < 4; r++) begin
            pre = int'($urandom_range(0, 255));
            pt  = int'($urandom_range(0, 15));
            ini = int'($urandom_range(0, 255));
            for (int j = 0; j < RAW_LEN; j++) src_m[j] = 8'($urandom_range(0, 255));
            setup(pre, pt, ini); model_encrypt(pre, pt, ini);
            do_run(1'b0, -1, -1, ack_n, we_n);
            check_val($sformatf("rnd%0d_lat", r), 32'(ack_n), 32'd133);
            check_val($sformatf("rnd%0d_cfg_err", r), 32'(cfg_err), 32'(exp_cfg_err));
            check_cipher($sformatf("rnd%0d", r), MSG_LEN);
            do_run(1'b1, -1, -1, ack_n, we_n);
            check_val($sformatf("rnd%0d_par", r), 32'(par_err_cnt), 32'd0);
            check_plain($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
